// File: rtl/arr_loader_if.sv
// Memory write-port bundle between arr_loader (master) and the memory (slave).
// Carries the AW, W and B channels; clock and reset stay as plain ports.
interface arr_loader_if #(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32,
   parameter int RESP_WDTH = 1
);
   logic                 aw_valid;
   logic                 aw_ready;
   logic [ADDR_WDTH-1:0] aw_address;
   logic                 w_valid;
   logic                 w_ready;
   logic [DATA_WDTH-1:0] w_data;
   logic                 b_valid;
   logic                 b_ready;
   logic [RESP_WDTH-1:0] b_resp;

   modport master (
      output aw_valid, aw_address, w_valid, w_data, b_ready,
      input  aw_ready, w_ready, b_valid, b_resp
   );

   modport slave (
      input  aw_valid, aw_address, w_valid, w_data, b_ready,
      output aw_ready, w_ready, b_valid, b_resp
   );
endinterface

// File: rtl/arr_loader.sv
// arr_loader: fills memory words 0..arr_size-1 with a Galois LFSR sequence
// over the AW/W/B write channels, then pulses sort_start to the sorter.
// Optional feature macro: ARR_LOADER_RETRY_EN -- when defined, a word that
// receives an error response is re-sent up to MAX_RETRY more times before
// the fill aborts; when undefined the first error response aborts the fill.
module arr_loader #(
   parameter int                 ADDR_WDTH = 4,
   parameter int                 DATA_WDTH = 32,
   parameter int                 RESP_WDTH = 1,
   parameter logic [DATA_WDTH-1:0] LFSR_TAPS = 32'h8020_0003,
   parameter int                 MAX_RETRY = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDR_WDTH:0]   arr_size,
   input  logic                 load,
   input  logic [DATA_WDTH-1:0] seed,
   arr_loader_if.master         mem,
   output logic                 sort_start,
   output logic                 loaded,
   output logic                 err
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEND = 3'd1,
      RESP = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

   // Largest legal fill size is the full memory depth.
   localparam logic [ADDR_WDTH:0] DEPTH = {1'b1, {ADDR_WDTH{1'b0}}};

   state_t                 state_q, state_d;
   logic [ADDR_WDTH:0]     size_q, size_d;
   logic [ADDR_WDTH-1:0]   index_q, index_d;
   logic [DATA_WDTH-1:0]   lfsr_q, lfsr_d;
   logic                   aw_done_q, aw_done_d;
   logic                   w_done_q, w_done_d;
   logic                   sort_start_q, sort_start_d;

`ifdef ARR_LOADER_RETRY_EN
   localparam int RTRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RTRY_W-1:0]      retry_q, retry_d;
`endif

   logic aw_fire;
   logic w_fire;
   logic b_fire;
   logic resp_ok;
   logic last_word;

   // One Galois LFSR step: shift right, fold the taps in when a 1 falls out.
   function automatic logic [DATA_WDTH-1:0] lfsr_step(input logic [DATA_WDTH-1:0] s);
      logic [DATA_WDTH-1:0] shifted;
      shifted = s >> 1;
      return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
   endfunction

   // Each valid drops independently once its own handshake has completed.
   assign mem.aw_valid   = (state_q == SEND) && !aw_done_q;
   assign mem.w_valid    = (state_q == SEND) && !w_done_q;
   assign mem.b_ready    = (state_q == RESP);
   assign mem.aw_address = index_q;
   assign mem.w_data     = lfsr_q;

   assign sort_start = sort_start_q;
   assign loaded     = (state_q == DONE);
   assign err        = (state_q == ERR);

   assign aw_fire   = mem.aw_valid && mem.aw_ready;
   assign w_fire    = mem.w_valid && mem.w_ready;
   assign b_fire    = mem.b_ready && mem.b_valid;
   assign resp_ok   = (mem.b_resp == '0);
   assign last_word = ({1'b0, index_q} == (size_q - (ADDR_WDTH + 1)'(1)));

   // Next-state logic: load acceptance, per-word handshakes and response handling.
   always_comb begin
      state_d      = state_q;
      size_d       = size_q;
      index_d      = index_q;
      lfsr_d       = lfsr_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      sort_start_d = 1'b0;
`ifdef ARR_LOADER_RETRY_EN
      retry_d      = retry_q;
`endif

      case (state_q)
         IDLE, DONE, ERR: begin
            if (load) begin
               size_d    = arr_size;
               lfsr_d    = (seed == '0) ? DATA_WDTH'(1) : seed;
               index_d   = '0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
`ifdef ARR_LOADER_RETRY_EN
               retry_d   = '0;
`endif
               if (arr_size == '0) begin
                  state_d = DONE;
               end else if (arr_size > DEPTH) begin
                  state_d = ERR;
               end else begin
                  state_d = SEND;
               end
            end
         end

         SEND: begin
            if (aw_fire) begin
               aw_done_d = 1'b1;
            end
            if (w_fire) begin
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = RESP;
            end
         end

         RESP: begin
            if (b_fire) begin
               if (resp_ok) begin
`ifdef ARR_LOADER_RETRY_EN
                  retry_d = '0;
`endif
                  if (last_word) begin
                     state_d      = DONE;
                     sort_start_d = 1'b1;
                  end else begin
                     index_d = index_q + ADDR_WDTH'(1);
                     lfsr_d  = lfsr_step(lfsr_q);
                     state_d = SEND;
                  end
               end else begin
`ifdef ARR_LOADER_RETRY_EN
                  if (retry_q < RTRY_W'(MAX_RETRY)) begin
                     retry_d = retry_q + RTRY_W'(1);
                     state_d = SEND;
                  end else begin
                     state_d = ERR;
                  end
`else
                  state_d = ERR;
`endif
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset clearing every flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         size_q       <= '0;
         index_q      <= '0;
         lfsr_q       <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         sort_start_q <= 1'b0;
`ifdef ARR_LOADER_RETRY_EN
         retry_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         size_q       <= size_d;
         index_q      <= index_d;
         lfsr_q       <= lfsr_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         sort_start_q <= sort_start_d;
`ifdef ARR_LOADER_RETRY_EN
         retry_q      <= retry_d;
`endif
      end
   end

endmodule

// File: tb/tb_arr_loader.sv
// Self-checking bench for arr_loader: a table of fill scenarios plus
// hand-written sequences for a mid-fill load and a mid-fill reset.
module tb_arr_loader;

   localparam int EXP_BAD_WRITES =
`ifdef ARR_LOADER_RETRY_EN
      4;
`else
      1;
`endif

   typedef struct {
      logic [31:0] seed;
      logic [4:0]  size;
      bit          stall;
      bit          bad_resp;
      bit          exp_loaded;
      bit          exp_err;
      int          exp_writes;
      int          exp_sort;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  arr_size;
   logic        load;
   logic [31:0] seed;
   logic        sort_start;
   logic        loaded;
   logic        err;

   int checks = 0;
   int errors = 0;

   // memory-side model state, written only by the responder process
   logic [31:0] mem_model [16];
   int          aw_cnt [16];
   int          aw_total, w_total, b_total, sort_cnt, sort_b;
   bit          got_aw, got_w;
   logic [3:0]  cur_addr, prev_addr;
   logic [31:0] cur_data, prev_data;
   bit          prev_aw_wait, prev_w_wait;

   // controls written by the main initial block
   bit stall_mode = 1'b0;
   bit bad_mode   = 1'b0;
   bit clear_stats = 1'b0;

   vec_t vecs [7];

   arr_loader_if #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) mem_if ();

   arr_loader #(
      .ADDR_WDTH(4),
      .DATA_WDTH(32),
      .RESP_WDTH(1),
      .LFSR_TAPS(32'h8020_0003),
      .MAX_RETRY(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .arr_size(arr_size),
      .load(load),
      .seed(seed),
      .mem(mem_if),
      .sort_start(sort_start),
      .loaded(loaded),
      .err(err)
   );

   always #5 clk = ~clk;

   // compare one value and report it
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] modelNext(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   // Memory responder: drives readys and B at the falling edge, and records
   // the handshakes that the next rising edge will complete.
   always @(negedge clk) begin
      if (!rst_n || clear_stats) begin
         for (int a = 0; a < 16; a++) begin
            mem_model[a] = 32'h0;
            aw_cnt[a] = 0;
         end
         aw_total = 0; w_total = 0; b_total = 0; sort_cnt = 0; sort_b = 0;
         got_aw = 1'b0; got_w = 1'b0;
         cur_addr = 4'h0; cur_data = 32'h0;
         prev_aw_wait = 1'b0; prev_w_wait = 1'b0;
         prev_addr = 4'h0; prev_data = 32'h0;
         mem_if.aw_ready = 1'b0;
         mem_if.w_ready  = 1'b0;
         mem_if.b_valid  = 1'b0;
         mem_if.b_resp   = 1'b0;
      end else begin
         if (prev_aw_wait) begin
            checkOutput("aw_hold_valid", 32'(mem_if.aw_valid), 32'd1);
            checkOutput("aw_hold_addr", 32'(mem_if.aw_address), 32'(prev_addr));
         end
         if (prev_w_wait) begin
            checkOutput("w_hold_valid", 32'(mem_if.w_valid), 32'd1);
            checkOutput("w_hold_data", mem_if.w_data, prev_data);
         end
         mem_if.b_valid  = got_aw && got_w;
         mem_if.b_resp   = bad_mode;
         mem_if.aw_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         mem_if.w_ready  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (mem_if.aw_valid && mem_if.aw_ready) begin
            aw_total++;
            aw_cnt[mem_if.aw_address]++;
            cur_addr = mem_if.aw_address;
            got_aw = 1'b1;
         end
         if (mem_if.w_valid && mem_if.w_ready) begin
            w_total++;
            cur_data = mem_if.w_data;
            got_w = 1'b1;
         end
         prev_aw_wait = mem_if.aw_valid && !mem_if.aw_ready;
         prev_addr    = mem_if.aw_address;
         prev_w_wait  = mem_if.w_valid && !mem_if.w_ready;
         prev_data    = mem_if.w_data;
         if (mem_if.b_valid && mem_if.b_ready) begin
            b_total++;
            if (!bad_mode) mem_model[cur_addr] = cur_data;
            got_aw = 1'b0;
            got_w = 1'b0;
         end
         if (sort_start) begin
            sort_cnt++;
            sort_b = b_total;
         end
      end
   end

   task automatic clearStats();
      clear_stats = 1'b1;
      repeat (2) @(negedge clk);
      clear_stats = 1'b0;
   endtask

   // drive one load pulse; returns at the falling edge after acceptance
   task automatic startLoad(input logic [4:0] size, input logic [31:0] sd);
      @(negedge clk);
      arr_size = size;
      seed = sd;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      bit found;
      found = 1'b0;
      for (int c = 0; c < 3000 && !found; c++) begin
         if (loaded || err) found = 1'b1;
         else @(negedge clk);
      end
      if (!found) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic checkContents(input string tag, input logic [31:0] sd, input int size);
      logic [31:0] s;
      s = (sd == 32'h0) ? 32'h1 : sd;
      for (int a = 0; a < size; a++) begin
         checkOutput({tag, "_word"}, mem_model[a], s);
         checkOutput({tag, "_aw_once"}, 32'(aw_cnt[a]), 32'd1);
         s = modelNext(s);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      clearStats();
      stall_mode = v.stall;
      bad_mode = v.bad_resp;
      startLoad(v.size, v.seed);
      if (v.size == 5'd0) checkOutput({tag, "_loaded_next"}, 32'(loaded), 32'd1);
      if (v.size > 5'd16) checkOutput({tag, "_err_next"}, 32'(err), 32'd1);
      waitDone(tag);
      checkOutput({tag, "_loaded"}, 32'(loaded), 32'(v.exp_loaded));
      checkOutput({tag, "_err"}, 32'(err), 32'(v.exp_err));
      checkOutput({tag, "_aw_total"}, 32'(aw_total), 32'(v.exp_writes));
      checkOutput({tag, "_w_total"}, 32'(w_total), 32'(v.exp_writes));
      checkOutput({tag, "_sort_cnt"}, 32'(sort_cnt), 32'(v.exp_sort));
      if (v.exp_sort > 0) checkOutput({tag, "_sort_after_b"}, 32'(sort_b), 32'(v.size));
      if (v.exp_loaded) checkContents(tag, v.seed, int'(v.size));
      if (v.bad_resp) checkOutput({tag, "_addr0_attempts"}, 32'(aw_cnt[0]), 32'(v.exp_writes));
   endtask

   initial begin
      arr_size = 5'd0;
      load = 1'b0;
      seed = 32'h0;

      vecs[0] = '{seed: 32'h1,        size: 5'd4,  stall: 1'b0, bad_resp: 1'b0,
                  exp_loaded: 1'b1, exp_err: 1'b0, exp_writes: 4,  exp_sort: 1};
      vecs[1] = '{seed: 32'h0,        size: 5'd1,  stall: 1'b0, bad_resp: 1'b0,
                  exp_loaded: 1'b1, exp_err: 1'b0, exp_writes: 1,  exp_sort: 1};
      vecs[2] = '{seed: 32'hABCD,     size: 5'd0,  stall: 1'b0, bad_resp: 1'b0,
                  exp_loaded: 1'b1, exp_err: 1'b0, exp_writes: 0,  exp_sort: 0};
      vecs[3] = '{seed: 32'h1,        size: 5'd17, stall: 1'b0, bad_resp: 1'b0,
                  exp_loaded: 1'b0, exp_err: 1'b1, exp_writes: 0,  exp_sort: 0};
      vecs[4] = '{seed: 32'hDEADBEEF, size: 5'd16, stall: 1'b1, bad_resp: 1'b0,
                  exp_loaded: 1'b1, exp_err: 1'b0, exp_writes: 16, exp_sort: 1};
      vecs[5] = '{seed: 32'h1,        size: 5'd3,  stall: 1'b0, bad_resp: 1'b1,
                  exp_loaded: 1'b0, exp_err: 1'b1, exp_writes: EXP_BAD_WRITES, exp_sort: 0};
      vecs[6] = '{seed: 32'h12345678, size: 5'd5,  stall: 1'b1, bad_resp: 1'b0,
                  exp_loaded: 1'b1, exp_err: 1'b0, exp_writes: 5,  exp_sort: 1};

      // reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_aw_valid", 32'(mem_if.aw_valid), 32'd0);
      checkOutput("rst_w_valid", 32'(mem_if.w_valid), 32'd0);
      checkOutput("rst_b_ready", 32'(mem_if.b_ready), 32'd0);
      checkOutput("rst_aw_address", 32'(mem_if.aw_address), 32'd0);
      checkOutput("rst_w_data", mem_if.w_data, 32'd0);
      checkOutput("rst_outputs", {29'd0, sort_start, loaded, err}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
         if (i == 0) begin
            checkOutput("seq1_addr0", mem_model[0], 32'h0000_0001);
            checkOutput("seq1_addr1", mem_model[1], 32'h8020_0003);
            checkOutput("seq1_addr2", mem_model[2], 32'hC030_0002);
            checkOutput("seq1_addr3", mem_model[3], 32'h6018_0001);
         end
      end

      // a second load during the fill must be ignored
      clearStats();
      stall_mode = 1'b1;
      bad_mode = 1'b0;
      startLoad(5'd8, 32'hCAFE_0001);
      repeat (5) @(negedge clk);
      arr_size = 5'd2;
      seed = 32'h77;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      waitDone("midload");
      checkOutput("midload_loaded", 32'(loaded), 32'd1);
      checkOutput("midload_aw_total", 32'(aw_total), 32'd8);
      checkOutput("midload_sort_cnt", 32'(sort_cnt), 32'd1);
      checkContents("midload", 32'hCAFE_0001, 8);

      // reset during the response phase of word 2
      clearStats();
      stall_mode = 1'b0;
      startLoad(5'd4, 32'h1);
      begin
         bit found;
         found = 1'b0;
         for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (mem_if.b_ready && mem_if.aw_address == 4'd2) found = 1'b1;
         end
         checkOutput("rstmid_reached_word2", 32'(found), 32'd1);
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstmid_aw_valid", 32'(mem_if.aw_valid), 32'd0);
      checkOutput("rstmid_w_valid", 32'(mem_if.w_valid), 32'd0);
      checkOutput("rstmid_b_ready", 32'(mem_if.b_ready), 32'd0);
      checkOutput("rstmid_aw_address", 32'(mem_if.aw_address), 32'd0);
      checkOutput("rstmid_w_data", mem_if.w_data, 32'd0);
      checkOutput("rstmid_outputs", {29'd0, sort_start, loaded, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clearStats();
      startLoad(5'd3, 32'h5);
      waitDone("restart");
      checkOutput("restart_loaded", 32'(loaded), 32'd1);
      checkOutput("restart_aw_total", 32'(aw_total), 32'd3);
      checkContents("restart", 32'h5, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arr_loader.md
Name: arr_loader

Overview:
- Upstream stage of sort_circuit.
- On `load`, fills memory addresses 0..arr_size-1 over the AW/W/B write channels with a pseudo-random word sequence from an internal Galois LFSR.
- After the last write is acknowledged with OKAY, pulses `sort_start` into the sorter's `start` input.
- Shares the memory write port with the sorter, muxed by the top level; the loader owns the port only while busy.

Parameters:
- ADDR_WDTH, 4, memory address width; depth = 2**ADDR_WDTH words.
- DATA_WDTH, 32, data word width.
- RESP_WDTH, 1, response width; 0 = OKAY, nonzero = error.
- LFSR_TAPS, 32'h8020_0003, Galois tap mask, sized DATA_WDTH.
- MAX_RETRY, 3, extra attempts per word; used only with ARR_LOADER_RETRY_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- arr_size  in  ADDR_WDTH+1  number of words to write; sampled on load acceptance.
- load  in  1  start request; accepted only in IDLE/DONE/ERR.
- seed  in  DATA_WDTH  LFSR seed; sampled on load acceptance.
- aw_valid  out  1  write address valid.
- aw_ready  in  1  write address ready.
- aw_address  out  ADDR_WDTH  write address.
- w_valid  out  1  write data valid.
- w_ready  in  1  write data ready.
- w_data  out  DATA_WDTH  write data.
- b_valid  in  1  write response valid.
- b_ready  out  1  write response ready.
- b_resp  in  RESP_WDTH  write response.
- sort_start  out  1  one-cycle pulse to the sorter.
- loaded  out  1  level; fill completed OK.
- err  out  1  level; fill aborted.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; all outputs 0, including aw_address, w_data, index, LFSR and retry count. Applies mid-transfer: valids drop on that edge.
- FSM states: IDLE, SEND, RESP, DONE, ERR.
- IDLE/DONE/ERR with load=1:
  - Latch arr_size.
  - LFSR <= (seed==0 ? 1 : seed).
  - index <= 0; clear loaded and err.
  - If arr_size==0, go to DONE without writes or sort_start pulse.
  - If arr_size > 2**ADDR_WDTH, go to ERR.
  - Otherwise go to SEND.
- SEND:
  - aw_valid=w_valid=1, aw_address=index[ADDR_WDTH-1:0], w_data=LFSR.
  - Each valid is held until its own ready is sampled high, then drops independently. Both may complete in the same cycle.
  - Address and data stay stable while their valid is high.
  - Move to RESP once both handshakes have completed.
- RESP:
  - b_ready=1 until b_valid.
  - OKAY and index==size-1: go to DONE and assert sort_start for exactly that one cycle.
  - OKAY otherwise: index+1; LFSR advances (s>>1 if s[0]==0, else (s>>1)^LFSR_TAPS); go to SEND.
  - Error response: go to ERR (see optional feature).
- Minimum throughput: 2 cycles per word with all readys tied high and b_valid one cycle after W.
- DONE: loaded=1, held until the next load or reset. ERR: err=1, same hold rule. loaded and err are never both 1.
- load while in SEND/RESP is ignored. arr_size and seed changes mid-fill are ignored.
- b_valid outside RESP is ignored; b_ready is 0 outside RESP.

Optional Feature:
- Macro: ARR_LOADER_RETRY_EN.
- Defined: an error response in RESP re-enters SEND with the same index and data and increments the retry count. The count clears on each OKAY. ERR is entered only after MAX_RETRY retries of one word also fail (MAX_RETRY+1 attempts total).
- Undefined: the first error response goes to ERR; no retry counter is synthesized.

Test Plan:
- seed=1, arr_size=4, memory always_success -> writes addr0..3 = 0x00000001, 0x80200003, 0xC0300002, 0x60180001; one sort_start pulse after the 4th B; loaded=1, err=0.
- seed=0, arr_size=1 -> single write addr0=0x00000001; sort_start pulses once.
- arr_size=0 -> no aw_valid ever; loaded=1 one cycle after load; sort_start never pulses. Separately arr_size=17 (ADDR_WDTH=4) -> err=1, no writes.
- always_error, arr_size=3 -> macro off: one AW/W to addr0, then err=1 and no sort_start. Macro on: 4 attempts to addr0, then err=1.
- Random aw_ready/w_ready stalls, and a load pulse mid-fill -> aw_address/w_data stable while valid; AW and W each accepted once per word; extra load ignored; final contents match the LFSR sequence.
- rst_n low during the RESP of word 2 -> next cycle all outputs 0 and state IDLE; a new load restarts from addr0 with the new seed.
